// File: rtl/fifo_write_master.sv
// Avalon-MM write master fed by a show-ahead FIFO. A go pulse loads base/length;
// one beat is issued per cycle whenever the FIFO has data and bytes remain.
module fifo_write_master #(
   parameter int DATAWIDTH       = 32,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int FIFODEPTH       = 32,
   parameter int FIFODEPTH_LOG2  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       control_go,
   input  logic [ADDRESSWIDTH-1:0]    control_write_base,
   input  logic [ADDRESSWIDTH-1:0]    control_write_length,
   input  logic                       control_fixed_location,
   output logic                       control_done,
   input  logic                       user_write_buffer,
   input  logic [DATAWIDTH-1:0]       user_buffer_data,
   output logic                       user_buffer_full,
   output logic [FIFODEPTH_LOG2:0]    fifo_used,
   output logic [ADDRESSWIDTH-1:0]    master_address,
   output logic                       master_write,
   output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
   output logic [DATAWIDTH-1:0]       master_writedata,
   input  logic                       master_waitrequest
);

   localparam logic [ADDRESSWIDTH-1:0]   STEP       = ADDRESSWIDTH'(BYTEENABLEWIDTH);
   localparam logic [ADDRESSWIDTH-1:0]   LEN_MASK   = ~(STEP - ADDRESSWIDTH'(1));
   localparam logic [FIFODEPTH_LOG2:0]   FULL_COUNT = (FIFODEPTH_LOG2 + 1)'(FIFODEPTH);

   logic [DATAWIDTH-1:0]      r_mem [FIFODEPTH];
   logic [FIFODEPTH_LOG2-1:0] r_wr_ptr;
   logic [FIFODEPTH_LOG2-1:0] r_rd_ptr;
   logic [FIFODEPTH_LOG2:0]   r_used;
   logic [ADDRESSWIDTH-1:0]   r_address;
   logic [ADDRESSWIDTH-1:0]   r_length;
   logic                      r_fixed_d1;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_idle;

   assign w_idle  = (r_length == '0);
   assign w_push  = user_write_buffer & ~user_buffer_full;
   assign w_pop   = master_write & ~master_waitrequest;

   // Storage carries no reset; validity is tracked by the pointers and r_used.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= user_buffer_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_used   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_used <= r_used + 1'b1;
            2'b01:   r_used <= r_used - 1'b1;
            default: r_used <= r_used;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_address  <= '0;
         r_length   <= '0;
         r_fixed_d1 <= 1'b0;
      end else if (control_go && w_idle) begin
         r_address  <= control_write_base;
         r_length   <= control_write_length & LEN_MASK;
         r_fixed_d1 <= control_fixed_location;
      end else if (w_pop) begin
         r_length <= r_length - STEP;
         if (!r_fixed_d1) r_address <= r_address + STEP;
      end
   end

   assign control_done      = w_idle;
   assign fifo_used         = r_used;
   assign user_buffer_full  = (r_used == FULL_COUNT);
   assign master_write      = ~w_idle & (r_used != '0);
   assign master_address    = r_address;
   assign master_byteenable = '1;
   assign master_writedata  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_fifo_write_master.sv
// Directed bench for fifo_write_master: linear stimulus, immediate assertions against
// hand-computed expectations.
module tb_fifo_write_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        control_go;
   logic [31:0] control_write_base;
   logic [31:0] control_write_length;
   logic        control_fixed_location;
   logic        control_done;
   logic        user_write_buffer;
   logic [31:0] user_buffer_data;
   logic        user_buffer_full;
   logic [5:0]  fifo_used;
   logic [31:0] master_address;
   logic        master_write;
   logic [3:0]  master_byteenable;
   logic [31:0] master_writedata;
   logic        master_waitrequest;

   int n_checks = 0;
   int n_fails  = 0;

   fifo_write_master dut (
      .clk                    (clk),
      .reset                  (reset),
      .control_go             (control_go),
      .control_write_base     (control_write_base),
      .control_write_length   (control_write_length),
      .control_fixed_location (control_fixed_location),
      .control_done           (control_done),
      .user_write_buffer      (user_write_buffer),
      .user_buffer_data       (user_buffer_data),
      .user_buffer_full       (user_buffer_full),
      .fifo_used              (fifo_used),
      .master_address         (master_address),
      .master_write           (master_write),
      .master_byteenable      (master_byteenable),
      .master_writedata       (master_writedata),
      .master_waitrequest     (master_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      user_write_buffer = 1'b1;
      user_buffer_data  = d;
      tick();
      user_write_buffer = 1'b0;
   endtask

   task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
      control_go             = 1'b1;
      control_write_base     = base;
      control_write_length   = len;
      control_fixed_location = fixed;
      tick();
      control_go = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, "_write"}, master_write, 1'b1);
      chk({tag, "_addr"}, master_address, addr);
      chk({tag, "_data"}, master_writedata, data);
   endtask

   initial begin
      reset = 1'b1;
      control_go = 1'b0;
      control_write_base = '0;
      control_write_length = '0;
      control_fixed_location = 1'b0;
      user_write_buffer = 1'b0;
      user_buffer_data = '0;
      master_waitrequest = 1'b0;
      #3;
      chk("rst_write", master_write, 1'b0);
      chk("rst_addr", master_address, 32'h0);
      chk("rst_done", control_done, 1'b1);
      chk("rst_full", user_buffer_full, 1'b0);
      chk("rst_used", fifo_used, 6'd0);
      chk("rst_be", master_byteenable, 4'hF);
      tick();
      reset = 1'b0;
      tick();

      // Pre-filled FIFO, four back-to-back beats.
      for (int i = 0; i < 4; i++) push(32'hA000_0000 + i);
      chk("pre_used", fifo_used, 6'd4);
      chk("pre_write", master_write, 1'b0);
      chk("pre_head", master_writedata, 32'hA000_0000);
      go(32'h100, 32'd16, 1'b0);
      chk("a_done", control_done, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("a%0d", i), 32'h100 + 32'(4 * i), 32'hA000_0000 + i);
         tick();
      end
      chk("a_done_end", control_done, 1'b1);
      chk("a_used_end", fifo_used, 6'd0);
      chk("a_write_end", master_write, 1'b0);

      // Fixed location, data arrives after go.
      go(32'h200, 32'd8, 1'b1);
      chk("b_done", control_done, 1'b0);
      chk("b_idle_write", master_write, 1'b0);
      push(32'hB000_0000);
      beat("b0", 32'h200, 32'hB000_0000);
      tick();
      chk("b_gap_write", master_write, 1'b0);
      chk("b_gap_done", control_done, 1'b0);
      push(32'hB000_0001);
      beat("b1", 32'h200, 32'hB000_0001);
      tick();
      chk("b_done_end", control_done, 1'b1);
      chk("b_addr_end", master_address, 32'h200);

      // Stall on beat 2, plus an ignored go while busy.
      for (int i = 0; i < 4; i++) push(32'hC000_0000 + i);
      go(32'h300, 32'd16, 1'b0);
      beat("c0", 32'h300, 32'hC000_0000);
      tick();
      master_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("c1_stall%0d", i), 32'h304, 32'hC000_0001);
         chk($sformatf("c1_stall%0d_used", i), fifo_used, 6'd3);
         if (i == 1) begin
            control_go = 1'b1;
            control_write_base = 32'h900;
            control_write_length = 32'd64;
         end
         tick();
         control_go = 1'b0;
      end
      master_waitrequest = 1'b0;
      beat("c1", 32'h304, 32'hC000_0001);
      tick();
      beat("c2", 32'h308, 32'hC000_0002);
      tick();
      beat("c3", 32'h30C, 32'hC000_0003);
      tick();
      chk("c_done_end", control_done, 1'b1);
      chk("c_addr_end", master_address, 32'h310);

      // Sub-word length gives no beats; the leftover word stays queued.
      push(32'hE000_0000);
      go(32'h800, 32'd3, 1'b0);
      chk("z_done", control_done, 1'b1);
      chk("z_write", master_write, 1'b0);
      tick();
      chk("z_used", fifo_used, 6'd1);

      // Fill to full, drop the 33rd push, then push+pop at 31.
      for (int i = 0; i < 31; i++) push(32'hD000_0000 + i);
      chk("f_full", user_buffer_full, 1'b1);
      chk("f_used", fifo_used, 6'd32);
      push(32'hDEAD_BEEF);
      chk("f_drop_used", fifo_used, 6'd32);
      chk("f_drop_full", user_buffer_full, 1'b1);
      go(32'h400, 32'd8, 1'b0);
      beat("f0", 32'h400, 32'hE000_0000);
      tick();
      chk("f_used31", fifo_used, 6'd31);
      beat("f1", 32'h404, 32'hD000_0000);
      user_write_buffer = 1'b1;
      user_buffer_data = 32'hD000_001F;
      tick();
      user_write_buffer = 1'b0;
      chk("f_pushpop_used", fifo_used, 6'd31);
      chk("f_pushpop_head", master_writedata, 32'hD000_0001);
      chk("f_done", control_done, 1'b1);

      // Reset asserted between edges during beat 2.
      go(32'h500, 32'd16, 1'b0);
      beat("r0", 32'h500, 32'hD000_0001);
      tick();
      beat("r1", 32'h504, 32'hD000_0002);
      #2;
      reset = 1'b1;
      #1;
      chk("r_write", master_write, 1'b0);
      chk("r_used", fifo_used, 6'd0);
      chk("r_addr", master_address, 32'h0);
      chk("r_done", control_done, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      chk("r_done_after", control_done, 1'b1);
      chk("r_write_after", master_write, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
